// File: rtl/casez_matcher_pkg.sv
// Shared helpers and the default 3-bit wildcard table for the casez priority matcher.
package casez_matcher_pkg;

  localparam logic [11:0] DEF_PAT_VAL  = {3'b100, 3'b010, 3'b001, 3'b000};
  localparam logic [11:0] DEF_PAT_MASK = {3'b100, 3'b110, 3'b111, 3'b111};
  localparam logic [3:0]  DEF_PAT_OUT  = 4'b0011;

  // Index width with room for the extra "no match" code NPAT.
  function automatic int idx_w(input int npat);
    return $clog2(npat + 1);
  endfunction

  // Low bit of table entry idx inside a packed table of width-bit entries.
  function automatic int pat_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/casez_prio_match.sv
// Combinational wildcard priority decode: lowest matching table entry wins.
// Produces the winning index (NPAT when nothing matches), a hit flag and the decoded bit.
module casez_prio_match
  import casez_matcher_pkg::*;
#(
  parameter int                     WIDTH       = 3,
  parameter int                     NPAT        = 4,
  parameter logic [NPAT*WIDTH-1:0]  PAT_VAL     = DEF_PAT_VAL,
  parameter logic [NPAT*WIDTH-1:0]  PAT_MASK    = DEF_PAT_MASK,
  parameter logic [NPAT-1:0]        PAT_OUT     = DEF_PAT_OUT,
  parameter logic                   DEFAULT_OUT = 1'b0,
  parameter int                     IDX_W       = idx_w(NPAT)
) (
  input  logic [WIDTH-1:0] state,
  output logic [IDX_W-1:0] win_idx,
  output logic             hit,
  output logic             out_bit
);

  logic [NPAT-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NPAT; i++) begin
      match[i] = ((state ^ PAT_VAL[pat_lo(i, WIDTH) +: WIDTH])
                  & PAT_MASK[pat_lo(i, WIDTH) +: WIDTH]) == '0;
    end
  end

  // Scan from the lowest priority upward so the lowest matching index overwrites last.
  always_comb begin
    win_idx = IDX_W'(NPAT);
    hit     = 1'b0;
    out_bit = DEFAULT_OUT;
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_idx = IDX_W'(i);
        hit     = 1'b1;
        out_bit = PAT_OUT[i];
      end
    end
  end

endmodule

// File: rtl/casez_prio_matcher.sv
// Wildcard priority decoder with a single registered valid/ready output stage (1-cycle latency,
// in_ready = !out_valid || out_ready, no skid) and per-entry saturating hit counters.
module casez_prio_matcher
  import casez_matcher_pkg::*;
#(
  parameter int                     WIDTH       = 3,
  parameter int                     NPAT        = 4,
  parameter logic [NPAT*WIDTH-1:0]  PAT_VAL     = DEF_PAT_VAL,
  parameter logic [NPAT*WIDTH-1:0]  PAT_MASK    = DEF_PAT_MASK,
  parameter logic [NPAT-1:0]        PAT_OUT     = DEF_PAT_OUT,
  parameter logic                   DEFAULT_OUT = 1'b0,
  parameter int                     CNT_W       = 8,
  parameter int                     IDX_W       = idx_w(NPAT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_state,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  data_out,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_hit,
  input  logic                  clr_cnt,
  output logic [NPAT*CNT_W-1:0] hit_cnt
);

  logic [IDX_W-1:0] win_idx;
  logic             win_hit;
  logic             win_bit;
  logic             accept;

  casez_prio_match #(
    .WIDTH      (WIDTH),
    .NPAT       (NPAT),
    .PAT_VAL    (PAT_VAL),
    .PAT_MASK   (PAT_MASK),
    .PAT_OUT    (PAT_OUT),
    .DEFAULT_OUT(DEFAULT_OUT),
    .IDX_W      (IDX_W)
  ) u_match (
    .state  (in_state),
    .win_idx(win_idx),
    .hit    (win_hit),
    .out_bit(win_bit)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Result fields only move on accept, so they hold through stalls and idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= DEFAULT_OUT;
      out_idx   <= IDX_W'(NPAT);
      out_hit   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_out  <= win_bit;
      out_idx   <= win_idx;
      out_hit   <= win_hit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NPAT; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (clr_cnt) begin
        cnt <= '0;
      end else if (accept && win_hit && (win_idx == IDX_W'(g)) && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign hit_cnt[g*CNT_W +: CNT_W] = cnt;
  end

endmodule

// File: tb/tb_casez_prio_matcher.sv
// Randomized and directed checks of casez_prio_matcher against a string-pattern reference model.
module tb_casez_prio_matcher;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- dut0: default table ----------------
  logic        in_valid0, in_ready0, out_valid0, out_ready0, data_out0, out_hit0, clr0;
  logic [2:0]  in_state0, out_idx0;
  logic [31:0] hit_cnt0;

  casez_prio_matcher dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_state(in_state0), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready0), .data_out(data_out0), .out_idx(out_idx0),
    .out_hit(out_hit0), .clr_cnt(clr0), .hit_cnt(hit_cnt0)
  );

  // ---------------- dut1: 2-entry overlap table, 2-bit counters ----------------
  logic        in_valid1, in_ready1, out_valid1, out_ready1, data_out1, out_hit1, clr1;
  logic [2:0]  in_state1;
  logic [1:0]  out_idx1;
  logic [3:0]  hit_cnt1;

  casez_prio_matcher #(
    .WIDTH(3), .NPAT(2), .PAT_VAL(6'b000_101), .PAT_MASK(6'b000_111),
    .PAT_OUT(2'b01), .DEFAULT_OUT(1'b0), .CNT_W(2)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_state(in_state1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready1), .data_out(data_out1), .out_idx(out_idx1),
    .out_hit(out_hit1), .clr_cnt(clr1), .hit_cnt(hit_cnt1)
  );

  // ---------------- dut2: exact-match table that misses 0, default 1 ----------------
  logic        in_valid2, in_ready2, out_valid2, out_ready2, data_out2, out_hit2, clr2;
  logic [2:0]  in_state2, out_idx2;
  logic [31:0] hit_cnt2;

  casez_prio_matcher #(
    .WIDTH(3), .NPAT(4), .PAT_VAL(12'b111_110_101_100), .PAT_MASK(12'hFFF),
    .PAT_OUT(4'b0100), .DEFAULT_OUT(1'b1), .CNT_W(8)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_state(in_state2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .data_out(data_out2), .out_idx(out_idx2),
    .out_hit(out_hit2), .clr_cnt(clr2), .hit_cnt(hit_cnt2)
  );

  // ---------------- reference model for dut0 ----------------
  // Entries written as casez patterns, MSB first, '?' = don't care.
  string pats [4] = '{"000", "001", "01?", "1??"};
  bit    pouts[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  bit m_ov, m_data, m_hit;
  int m_idx;
  int m_cnt[4];

  function automatic void ref_match(input int st, output int idx, output bit d, output bit h);
    idx = 4; d = 1'b0; h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit ok = 1'b1;
      for (int b = 0; b < 3; b++) begin
        if (pats[i][b] != "?" && ((pats[i][b] == "1") != st[2-b])) ok = 1'b0;
      end
      if (ok) begin
        idx = i; d = pouts[i]; h = 1'b1;
        return;
      end
    end
  endfunction

  task automatic model_reset();
    m_ov = 0; m_data = 0; m_hit = 0; m_idx = 4;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, compare at the next negedge.
  task automatic step0(input bit v, input int s, input bit r, input bit c);
    int  i;
    bit  d, h, acc;
    logic [31:0] exp_cnt;
    in_valid0 = v; in_state0 = s[2:0]; out_ready0 = r; clr0 = c;
    #1;
    check("in_ready0", in_ready0, !m_ov || r);
    acc = v && (!m_ov || r);
    ref_match(s, i, d, h);
    if (c) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else if (acc && h && m_cnt[i] < 255) begin
      m_cnt[i]++;
    end
    if (acc) begin
      m_ov = 1; m_idx = i; m_data = d; m_hit = h;
    end else if (r) begin
      m_ov = 0;
    end
    @(negedge clk);
    exp_cnt = '0;
    for (int k = 0; k < 4; k++) exp_cnt[k*8 +: 8] = m_cnt[k][7:0];
    check("out_valid0", out_valid0, m_ov);
    check("data_out0", data_out0, m_data);
    check("out_idx0", out_idx0, m_idx);
    check("out_hit0", out_hit0, m_hit);
    check("hit_cnt0", hit_cnt0, exp_cnt);
  endtask

  task automatic step_b(input bit v1, input int s1, input bit c1, input bit v2, input int s2);
    in_valid1 = v1; in_state1 = s1[2:0]; clr1 = c1;
    in_valid2 = v2; in_state2 = s2[2:0];
    @(negedge clk);
  endtask

  int sweep_idx [8] = '{0, 1, 2, 2, 3, 3, 3, 3};
  bit sweep_dat [8] = '{1, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b1;
    in_valid0 = 0; in_state0 = 0; out_ready0 = 1; clr0 = 0;
    in_valid1 = 0; in_state1 = 0; out_ready1 = 1; clr1 = 0;
    in_valid2 = 0; in_state2 = 0; out_ready2 = 1; clr2 = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    check("rst out_valid0", out_valid0, 0);
    check("rst out_idx0", out_idx0, 4);
    check("rst data_out0", data_out0, 0);
    check("rst out_hit0", out_hit0, 0);
    check("rst hit_cnt0", hit_cnt0, 0);
    check("rst out_idx1", out_idx1, 2);
    check("rst data_out2", data_out2, 1);
    rst = 1'b0;

    // Default table sweep, checked against fixed expected tables as well as the model.
    for (int s = 0; s < 8; s++) begin
      step0(1, s, 1, 0);
      check("sweep idx", out_idx0, sweep_idx[s]);
      check("sweep data", data_out0, sweep_dat[s]);
      check("sweep hit", out_hit0, 1);
    end

    // Backpressure: accept one, then hold out_ready low with new inputs offered.
    step0(1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step0(1, 5, 0, 0);
      check("stall in_ready", in_ready0, 0);
      check("stall idx", out_idx0, 0);
      check("stall valid", out_valid0, 1);
    end
    step0(1, 5, 1, 0);
    check("release idx", out_idx0, 3);

    // Overlap table and no-match table.
    step_b(1, 5, 0, 1, 0);
    check("ovl in5 idx", out_idx1, 0);
    check("ovl in5 data", data_out1, 1);
    check("nomatch hit", out_hit2, 0);
    check("nomatch idx", out_idx2, 4);
    check("nomatch data", data_out2, 1);
    check("nomatch cnt", hit_cnt2, 0);
    step_b(1, 2, 0, 1, 6);
    check("ovl in2 idx", out_idx1, 1);
    check("ovl in2 data", data_out1, 0);
    check("exact in6 idx", out_idx2, 2);
    check("exact in6 data", data_out2, 1);
    check("exact in6 cnt", hit_cnt2, 32'h0001_0000);
    step_b(1, 5, 0, 1, 5);
    check("exact in5 idx", out_idx2, 1);
    check("exact in5 data", data_out2, 0);
    for (int k = 0; k < 3; k++) step_b(1, 5, 0, 0, 0);
    check("sat cnt", hit_cnt1, 4'b01_11);
    step_b(1, 5, 1, 0, 0);
    check("clr wins", hit_cnt1, 4'b00_00);
    check("clr datapath", out_valid1, 1);
    step_b(1, 5, 0, 0, 0);
    check("count after clr", hit_cnt1, 4'b00_01);
    step_b(0, 0, 0, 0, 0);
    check("drain valid1", out_valid1, 0);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      step0($urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    end

    // Reset while a result is pending and counters are live.
    step0(1, 0, 1, 0);
    step0(1, 3, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst out_valid0", out_valid0, 0);
    check("midrst out_idx0", out_idx0, 4);
    check("midrst out_hit0", out_hit0, 0);
    check("midrst hit_cnt0", hit_cnt0, 0);
    check("midrst hit_cnt1", hit_cnt1, 0);
    check("midrst in_ready0", in_ready0, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step0(1, 4, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
